// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// ---------------------------------------------------------------------------
// Packet transmitter feeding the 1x3 router input port. A send request
// (destination addr, payload length len) is latched in IDLE. The payload is
// then buffered from an upstream byte source, and header, payload and parity
// bytes are serialized onto the router input. The transmitter stalls while the
// router raises busy.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous, active-low reset
//   start    in   1  send request, only looked at in IDLE
//   addr     in   2  destination port 0..2 (3 is rejected)
//   len      in   6  payload byte count 1..63 (0 is rejected)
//   pl_data  in   8  payload byte from the upstream source
//   pl_vld   in   1  pl_data valid
//   pl_rdy   out  1  payload byte is taken this cycle
//   busy     in   1  router cannot take a byte this cycle
//   dout     out  8  byte to the router data input
//   pkt_vld  out  1  dout carries header or payload
//   tx_busy  out  1  transmitter is not idle
//   done     out  1  one-cycle pulse after the parity byte is taken
//   err      out  1  one-cycle pulse on an illegal start request
//   inj_err  in   1  only with ROUTER_TX_ERR_INJ_EN: corrupt parity bit 0
//
// Optional feature macro: ROUTER_TX_ERR_INJ_EN
//   When defined, inj_err is sampled together with start. A set inj_err
//   inverts bit 0 of the transmitted parity byte.
// ---------------------------------------------------------------------------
module router_pkt_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] len,
    input  logic [7:0] pl_data,
    input  logic       pl_vld,
    output logic       pl_rdy,
    input  logic       busy,
    output logic [7:0] dout,
    output logic       pkt_vld,
    output logic       tx_busy,
    output logic       done,
    output logic       err
`ifdef ROUTER_TX_ERR_INJ_EN
    ,
    input  logic       inj_err
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HDR  = 3'd2,
        ST_PLD  = 3'd3,
        ST_PAR  = 3'd4
    } state_t;

    // Running parity is a plain byte-wide XOR accumulation.
    function automatic logic [7:0] parity_fold(input logic [7:0] acc,
                                               input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

    state_t      state_r;
    state_t      state_s;

    logic [7:0]  mem_r [0:63];
    logic [7:0]  header_r;
    logic [7:0]  parity_r;
    logic [5:0]  wcnt_r;
    logic [5:0]  rptr_r;

    logic [7:0]  dout_r;
    logic        pkt_vld_r;
    logic        pl_rdy_r;
    logic        tx_busy_r;
    logic        done_r;
    logic        err_r;

    logic [7:0]  dout_s;
    logic        pkt_vld_s;
    logic        pl_rdy_s;
    logic        tx_busy_s;
    logic        done_s;
    logic        err_s;

    logic [5:0]  hdr_len_s;
    logic [5:0]  rptr_nx_s;
    logic [7:0]  par_byte_s;
    logic        start_bad_s;
    logic        start_ok_s;
    logic        load_acc_s;
    logic        load_last_s;
    logic        pld_last_s;

    assign hdr_len_s   = header_r[7:2];
    assign rptr_nx_s   = rptr_r + 6'd1;
    assign start_bad_s = start && ((addr == 2'd3) || (len == 6'd0));
    assign start_ok_s  = start && !start_bad_s;
    assign load_acc_s  = (state_r == ST_LOAD) && pl_vld;
    assign load_last_s = load_acc_s && (wcnt_r == (hdr_len_s - 6'd1));
    // rptr_r indexes the payload byte currently on dout while in PLD.
    assign pld_last_s  = (rptr_r == (hdr_len_s - 6'd1));

`ifdef ROUTER_TX_ERR_INJ_EN
    logic inj_r;

    // Capture the error-injection request alongside an accepted start
    always_ff @(posedge clk) begin
        if (!rst) begin
            inj_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_ok_s) begin
            inj_r <= inj_err;
        end
    end

    assign par_byte_s = parity_r ^ {7'b0000000, inj_r};
`else
    assign par_byte_s = parity_r;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a router transfer advances only when busy is low
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_s = ST_LOAD;
                else            state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_last_s) state_s = ST_HDR;
                else             state_s = ST_LOAD;
            end
            ST_HDR: begin
                if (!busy) state_s = ST_PLD;
                else       state_s = ST_HDR;
            end
            ST_PLD: begin
                if (!busy && pld_last_s) state_s = ST_PAR;
                else                     state_s = ST_PLD;
            end
            ST_PAR: begin
                if (!busy) state_s = ST_IDLE;
                else       state_s = ST_PAR;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; dout/pkt_vld hold while stalled
    always_comb begin
        dout_s    = dout_r;
        pkt_vld_s = pkt_vld_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        pl_rdy_s  = (state_s == ST_LOAD);
        tx_busy_s = (state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (start_bad_s) err_s = 1'b1;
                else             err_s = 1'b0;
            end
            ST_LOAD: begin
                if (load_last_s) begin
                    dout_s    = header_r;
                    pkt_vld_s = 1'b1;
                end else begin
                    dout_s    = dout_r;
                end
            end
            ST_HDR: begin
                if (!busy) dout_s = mem_r[6'd0];
                else       dout_s = dout_r;
            end
            ST_PLD: begin
                if (!busy && pld_last_s) begin
                    dout_s    = par_byte_s;
                    pkt_vld_s = 1'b0;
                end else if (!busy) begin
                    dout_s    = mem_r[rptr_nx_s];
                end else begin
                    dout_s    = dout_r;
                end
            end
            ST_PAR: begin
                if (!busy) begin
                    dout_s = 8'h00;
                    done_s = 1'b1;
                end else begin
                    dout_s = dout_r;
                end
            end
            default: begin
                dout_s    = 8'h00;
                pkt_vld_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_r    <= 8'h00;
            pkt_vld_r <= 1'b0;
            pl_rdy_r  <= 1'b0;
            tx_busy_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            dout_r    <= dout_s;
            pkt_vld_r <= pkt_vld_s;
            pl_rdy_r  <= pl_rdy_s;
            tx_busy_r <= tx_busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
        end
    end

    // Request latch, write/read counters and running parity
    always_ff @(posedge clk) begin
        if (!rst) begin
            header_r <= 8'h00;
            parity_r <= 8'h00;
            wcnt_r   <= 6'd0;
            rptr_r   <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        header_r <= {len, addr};
                        parity_r <= {len, addr};
                        wcnt_r   <= 6'd0;
                    end
                end
                ST_LOAD: begin
                    if (load_acc_s) begin
                        parity_r <= parity_fold(parity_r, pl_data);
                        wcnt_r   <= wcnt_r + 6'd1;
                    end
                end
                ST_HDR: begin
                    if (!busy) rptr_r <= 6'd0;
                end
                ST_PLD: begin
                    if (!busy) rptr_r <= rptr_nx_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Payload buffer; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (rst && load_acc_s) begin
            mem_r[wcnt_r] <= pl_data;
        end
    end

    assign dout    = dout_r;
    assign pkt_vld = pkt_vld_r;
    assign pl_rdy  = pl_rdy_r;
    assign tx_busy = tx_busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx. The bench acts as both payload
// source and router. The expected byte stream is header = len*4+addr, then
// the payload, then the XOR of all of these bytes. The stream is compared
// against what is observed on every cycle the bench lets the router accept a
// byte.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] pl_data;
    logic       pl_vld;
    logic       pl_rdy;
    logic       busy;
    logic [7:0] dout;
    logic       pkt_vld;
    logic       tx_busy;
    logic       done;
    logic       err;
`ifdef ROUTER_TX_ERR_INJ_EN
    logic       inj_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] pay [0:63];

    router_pkt_tx dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .addr    (addr),
        .len     (len),
        .pl_data (pl_data),
        .pl_vld  (pl_vld),
        .pl_rdy  (pl_rdy),
        .busy    (busy),
        .dout    (dout),
        .pkt_vld (pkt_vld),
        .tx_busy (tx_busy),
        .done    (done),
        .err     (err)
`ifdef ROUTER_TX_ERR_INJ_EN
        ,
        .inj_err (inj_err)
`endif
    );

    always #5 clk = ~clk;

    // Sends one packet. Entry and exit are 1 time unit after a rising edge.
    // stall_idx/stall_len force busy on a given stream byte. abort_at >= 0
    // resets the DUT after that many bytes have been accepted.
    task automatic run_packet(input logic [1:0] a, input logic [5:0] l,
                              input bit gap, input int busy_pct,
                              input int stall_idx, input int stall_len,
                              input bit inj, input int abort_at);
        logic [7:0] exp_s [0:65];
        logic [7:0] obs_d [0:65];
        logic       obs_v [0:65];
        logic [7:0] px;
        logic [7:0] prev_d;
        logic       prev_v;
        logic       prev_b;
        int wi, cyc, obs_n, xfer, busy_n, stalled;

        exp_s[0] = 8'(int'(l) * 4 + int'(a));
        px = exp_s[0];
        for (int i = 0; i < int'(l); i++) begin
            exp_s[i + 1] = pay[i];
            px = px ^ pay[i];
        end
        exp_s[int'(l) + 1] = px ^ {7'b0000000, inj};

        start = 1'b1; addr = a; len = l;
`ifdef ROUTER_TX_ERR_INJ_EN
        inj_err = inj;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (tx_busy !== 1'b1 || pl_rdy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_accept: tx_busy=%b pl_rdy=%b done=%b, required 1 1 0",
                     tx_busy, pl_rdy, done);
        end

        wi = 0; cyc = 0;
        while (wi < int'(l) && cyc < 1000) begin
            checks++;
            if (pl_rdy !== 1'b1 || pkt_vld !== 1'b0) begin
                errors++;
                $display("FAIL load_flags: pl_rdy=%b pkt_vld=%b, required 1 0", pl_rdy, pkt_vld);
            end
            busy  = 1'($urandom_range(1, 0));
            start = 1'($urandom_range(1, 0));
            addr  = 2'($urandom_range(3, 0));
            len   = 6'($urandom_range(63, 0));
            if (gap && (cyc % 2 == 1)) begin
                pl_vld = 1'b0;
            end else begin
                pl_vld  = 1'b1;
                pl_data = pay[wi];
            end
            @(posedge clk); #1;
            if (pl_vld) wi++;
            cyc++;
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL load_err: err=%b, required 0", err);
            end
        end
        pl_vld = 1'b0; start = 1'b0;
        checks++;
        if (wi != int'(l)) begin
            errors++;
            $display("FAIL load_timeout: accepted %0d bytes, required %0d", wi, l);
            return;
        end
        checks++;
        if (dout !== exp_s[0] || pkt_vld !== 1'b1 || pl_rdy !== 1'b0) begin
            errors++;
            $display("FAIL hdr_latency: dout=%h pkt_vld=%b pl_rdy=%b, required %h 1 0",
                     dout, pkt_vld, pl_rdy, exp_s[0]);
        end

        obs_n = 0; xfer = 0; busy_n = 0; stalled = 0; prev_b = 1'b0;
        prev_d = 8'h00; prev_v = 1'b0;
        while (obs_n < int'(l) + 2 && xfer < 2000) begin
            if (obs_n == abort_at) begin
                rst = 1'b0; busy = 1'b0; start = 1'b0;
                @(posedge clk); #1;
                checks++;
                if ({dout, pkt_vld, pl_rdy, tx_busy, done, err} !== 13'd0) begin
                    errors++;
                    $display("FAIL abort_reset: dout=%h pkt_vld=%b pl_rdy=%b tx_busy=%b done=%b err=%b, required all 0",
                             dout, pkt_vld, pl_rdy, tx_busy, done, err);
                end
                rst = 1'b1;
                return;
            end
            if (prev_b) begin
                checks++;
                if (dout !== prev_d || pkt_vld !== prev_v) begin
                    errors++;
                    $display("FAIL busy_hold: dout=%h pkt_vld=%b, required %h %b",
                             dout, pkt_vld, prev_d, prev_v);
                end
            end
            checks++;
            if (tx_busy !== 1'b1 || pl_rdy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL xfer_flags: tx_busy=%b pl_rdy=%b err=%b done=%b, required 1 0 0 0",
                         tx_busy, pl_rdy, err, done);
            end
            if (obs_n == stall_idx && stalled < stall_len) begin
                busy = 1'b1;
                stalled++;
            end else begin
                busy = (int'($urandom_range(99, 0)) < busy_pct) ? 1'b1 : 1'b0;
            end
            start = 1'($urandom_range(1, 0));
            addr  = 2'($urandom_range(3, 0));
            len   = 6'($urandom_range(63, 0));
            if (!busy) begin
                obs_d[obs_n] = dout;
                obs_v[obs_n] = pkt_vld;
                obs_n++;
            end else begin
                busy_n++;
            end
            prev_b = busy; prev_d = dout; prev_v = pkt_vld;
            @(posedge clk); #1;
            xfer++;
        end
        busy = 1'b0; start = 1'b0;

        checks++;
        if (obs_n != int'(l) + 2) begin
            errors++;
            $display("FAIL xfer_timeout: %0d bytes accepted, required %0d", obs_n, int'(l) + 2);
        end
        checks++;
        if (xfer != int'(l) + 2 + busy_n) begin
            errors++;
            $display("FAIL xfer_cycles: %0d cycles, required %0d", xfer, int'(l) + 2 + busy_n);
        end
        for (int i = 0; i < obs_n; i++) begin
            checks++;
            if (obs_d[i] !== exp_s[i] || obs_v[i] !== ((i <= int'(l)) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL stream_byte[%0d]: dout=%h pkt_vld=%b, required %h %b",
                         i, obs_d[i], obs_v[i], exp_s[i], (i <= int'(l)));
            end
        end
        checks++;
        if (done !== 1'b1 || tx_busy !== 1'b0 || pkt_vld !== 1'b0 || dout !== 8'h00 || pl_rdy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b tx_busy=%b pkt_vld=%b dout=%h pl_rdy=%b, required 1 0 0 00 0",
                     done, tx_busy, pkt_vld, dout, pl_rdy);
        end
    endtask

    task automatic idle_cycle_check();
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || tx_busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL idle_after: done=%b tx_busy=%b err=%b, required 0 0 0", done, tx_busy, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dout, pkt_vld, pl_rdy, tx_busy, done, err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: dout=%h pkt_vld=%b pl_rdy=%b tx_busy=%b done=%b err=%b, required all 0",
                     dout, pkt_vld, pl_rdy, tx_busy, done, err);
        end
        rst = 1'b1;
        idle_cycle_check();
    endtask

    task automatic load_basic();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    endtask

    task automatic test_basic();
        load_basic();
        run_packet(2'd1, 6'd3, 1'b0, 0, -1, 0, 1'b0, -1);
        idle_cycle_check();
    endtask

    task automatic test_busy_stall();
        load_basic();
        run_packet(2'd1, 6'd3, 1'b0, 0, 2, 2, 1'b0, -1);
        idle_cycle_check();
    endtask

    task automatic test_illegal();
        logic [1:0] a_tab [0:1];
        logic [5:0] l_tab [0:1];
        a_tab[0] = 2'd3; l_tab[0] = 6'd5;
        a_tab[1] = 2'd0; l_tab[1] = 6'd0;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; addr = a_tab[k]; len = l_tab[k];
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || tx_busy !== 1'b0 || pl_rdy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_err[%0d]: err=%b tx_busy=%b pl_rdy=%b, required 1 0 0",
                         k, err, tx_busy, pl_rdy);
            end
            idle_cycle_check();
        end
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        run_packet(2'd2, 6'd63, 1'b1, 0, -1, 0, 1'b0, -1);
        idle_cycle_check();
    endtask

    task automatic test_reset_mid();
        load_basic();
        run_packet(2'd1, 6'd3, 1'b0, 0, -1, 0, 1'b0, 3);
        run_packet(2'd1, 6'd3, 1'b0, 0, -1, 0, 1'b0, -1);
        idle_cycle_check();
    endtask

`ifdef ROUTER_TX_ERR_INJ_EN
    task automatic test_err_inj();
        load_basic();
        run_packet(2'd1, 6'd3, 1'b0, 0, -1, 0, 1'b1, -1);
        inj_err = 1'b0;
        idle_cycle_check();
    endtask
`endif

    // Random packets issued back to back: each start lands in the done cycle.
    task automatic test_back_to_back();
        logic [1:0] a;
        logic [5:0] l;
        for (int p = 0; p < 6; p++) begin
            a = 2'($urandom_range(2, 0));
            l = 6'($urandom_range(63, 1));
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(255, 0));
            run_packet(a, l, 1'($urandom_range(1, 0)), 30, -1, 0, 1'b0, -1);
        end
        idle_cycle_check();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; addr = 2'd0; len = 6'd0;
        pl_data = 8'h00; pl_vld = 1'b0; busy = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
        inj_err = 1'b0;
`endif
        test_reset();
        test_basic();
        test_busy_stall();
        test_illegal();
        test_max_len();
        test_reset_mid();
`ifdef ROUTER_TX_ERR_INJ_EN
        test_err_inj();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router's input port: it is the sending end of the packet protocol that the router's input register stage receives. It accepts a send request (destination address and payload length) and buffers the payload bytes from an upstream byte source. It then serializes header, payload and parity bytes onto the router input, stalling whenever the router asserts busy. It is used as the traffic source in subsystem benches and as the host-side packet framer.

## Interface
- No parameters; the payload buffer is fixed at 64 x 8 bits and the length field is fixed at 6 bits.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  send request; sampled only in IDLE.
- addr  input  2  destination port, 0..2; 3 is illegal.
- len  input  6  payload byte count, 1..63; 0 is illegal.
- pl_data  input  8  payload byte from the upstream source.
- pl_vld  input  1  pl_data is valid.
- pl_rdy  output  1  transmitter accepts a payload byte this cycle.
- busy  input  1  router cannot take a byte this cycle.
- dout  output  8  byte driven to the router data input.
- pkt_vld  output  1  dout carries a header or payload byte.
- tx_busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the parity byte is accepted.
- err  output  1  one-cycle pulse when a start request is illegal.
- inj_err  input  1  present only when ROUTER_TX_ERR_INJ_EN is defined.

## Operation
- States are IDLE, LOAD, HDR, PLD and PAR. All outputs are registered.
- IDLE:
  - start=1 with addr=3 or len=0: err pulses, state stays IDLE.
  - start=1 otherwise: latch header = {len, addr}, set parity = header, clear the write count, go to LOAD.
- LOAD:
  - pl_rdy=1.
  - Each cycle with pl_vld=1: write mem[wcnt] = pl_data, set parity ^= pl_data, increment wcnt.
  - On the len-th accepted byte: pl_rdy drops, dout = header, pkt_vld = 1, go to HDR.
- A byte is accepted by the router on any edge where the state is HDR, PLD or PAR and busy=0. While busy=1, dout and pkt_vld hold their values.
- HDR, when the header is accepted: dout = mem[0], clear rptr, go to PLD.
- PLD, on each accepted byte: increment rptr.
  - If more payload remains: dout = mem[rptr+1].
  - After the last payload byte: dout = parity, pkt_vld = 0, go to PAR.
- PAR, when the parity byte is accepted: dout = 0, done pulses, go to IDLE.
- start is ignored, with no err, in any state other than IDLE. A new start is accepted in the cycle where done is high.
- Parity is the XOR of the header and all payload bytes; it is 8 bits wide with no carry.
- rst=0 in any state:
  - Go to IDLE and abandon the packet.
  - dout=0, pkt_vld=0, pl_rdy=0, tx_busy=0, done=0, err=0.
  - Buffer contents are not reset.

## Timing
- Start accepted at edge T: pl_rdy=1 and tx_busy=1 from cycle T+1.
- Last payload byte accepted at edge L: the header appears on dout in cycle L+1.
- With busy held low, the router transfer takes exactly len+2 cycles:
  - pkt_vld is high for len+1 cycles (header plus payload).
  - pkt_vld is low for one cycle with the parity byte on dout.
- Each busy=1 cycle extends the transfer by exactly one cycle, with no byte lost or duplicated.
- busy has no effect in IDLE or LOAD.
- err and done are each high for exactly one cycle.

## Configuration
- ROUTER_TX_ERR_INJ_EN defined:
  - The inj_err port exists and is sampled together with start.
  - If inj_err=1, bit 0 of the transmitted parity byte is inverted, so the router flags a parity error.
- ROUTER_TX_ERR_INJ_EN undefined: the inj_err port is absent and parity is always correct.

## Test plan
- Basic packet: addr=1, len=3, payload 0x11, 0x22, 0x33, busy=0.
  - Required: dout sequence 0x0D, 0x11, 0x22, 0x33, 0x0D.
  - Required: pkt_vld 1,1,1,1,0, then done pulses.
- Busy stall: same packet with busy=1 for 2 cycles during payload byte 0x22.
  - Required: 0x22 held for 3 cycles with pkt_vld=1, then the sequence continues, for a total of 7 router cycles.
- Illegal requests: start with addr=3, then start with len=0.
  - Required: err pulses once for each, tx_busy stays 0, pl_rdy stays 0.
- Maximum length with gaps: addr=2, len=63, payload 0x00..0x3E, with pl_vld toggling every other cycle.
  - Required: header 0xFE, payload in order, parity equal to the XOR of all bytes, done pulses.
- Reset mid-packet: rst=0 in PLD after 2 payload bytes, followed by a fresh basic packet.
  - Required: outputs return to 0 the next cycle, and the fresh packet transmits correctly.
- Error injection (ROUTER_TX_ERR_INJ_EN defined): basic packet with inj_err=1.
  - Required: parity byte 0x0C.
